// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit with HI/LO registers: multi-cycle MULT/MULTU/DIV/DIVU
// plus single-cycle MTHI/MTLO writes. busy drives the hazard unit's D/E stall.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic [1:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic             launch, done;
  logic [63:0]      result;

  assign launch = (state == IDLE) && start;
  assign done   = (state == BUSY) && (count == CNT_W'(1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: default assignment first so no path through the case leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = BUSY;
      BUSY: if (count == CNT_W'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
  end

  // NOTE: operand registers are reset too; cheap here and keeps post-reset results deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (launch) begin
      count <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      op_q  <= md_op;
      a_q   <= rs_data;
      b_q   <= rt_data;
    end else if (state == BUSY) begin
      count <= count - CNT_W'(1);
    end
  end

  // Division runs on magnitudes so 0x80000000 / -1 cannot overflow; signs are reapplied after.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, den, uq, ur;

  always_comb begin
    neg_a  = (op_q == OP_DIV) && a_q[31];
    neg_b  = (op_q == OP_DIV) && b_q[31];
    mag_a  = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b  = neg_b ? (~b_q + 32'd1) : b_q;
    den    = (b_q == 32'd0) ? 32'd1 : mag_b;
    uq     = mag_a / den;
    ur     = mag_a % den;
    result = '0;
    case (op_q)
      OP_MULT:  result = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      OP_MULTU: result = {32'd0, a_q} * {32'd0, b_q};
      default: begin
        if (b_q == 32'd0) begin
          result = {a_q, 32'hFFFF_FFFF};
        end else begin
          result[31:0]  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
          result[63:32] = neg_a ? (~ur + 32'd1) : ur;
        end
      end
    endcase
  end

  // Completion has priority; MTHI/MTLO only land when idle and no start is launching.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= result[63:32];
      lo <= result[31:0];
    end else if (state == IDLE && !start) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at launch, popped when busy falls.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo;
  logic [1:0]  md_op;
  logic [31:0] rs_data, rt_data, wdata;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .mthi(mthi), .mtlo(mtlo), .rs_data(rs_data), .rt_data(rt_data),
    .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic sidesteps the 32-bit overflow corner.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
    endcase
    return res;
  endfunction

  // Drive a start pulse; returns 1ns after edge T with busy expected high.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(model(op, a, b));
    rs_data = $urandom; rt_data = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Count edges until busy falls (bounded), then compare against the scoreboard.
  task automatic wait_done(input int n, input string tag);
    int k;
    logic [63:0] e;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(n));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
  endtask

  initial begin
    logic [31:0] hold_hi;
    logic [1:0]  op;
    logic [31:0] a, b;
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    md_op = 2'b00; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    launch(2'b00, 32'hFFFF_FFFF, 32'd2);  wait_done(MC, "mult");
    launch(2'b01, 32'hFFFF_FFFF, 32'd2);  wait_done(MC, "multu");
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);  wait_done(DC, "div_neg");
    launch(2'b11, 32'd7, 32'd0);          wait_done(DC, "divu_zero");
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(DC, "div_ovf");
    launch(2'b10, 32'h1234_5678, 32'd0);  wait_done(DC, "div_zero");
    launch(2'b10, 32'd7, 32'hFFFF_FFFE);  wait_done(DC, "div_negdiv");

    // Start and mthi while busy must both be ignored.
    launch(2'b11, 32'd100, 32'd7);
    hold_hi = hi;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; md_op = 2'b00; mthi = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("busy_ignore_hi", 64'(hi), 64'(hold_hi));
    wait_done(DC - 3, "divu_ignore");
    @(posedge clk); #1;
    check("no_second_op", 64'(busy), 64'd0);

    // MTHI+MTLO together while idle.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_hi", 64'(hi), 64'h1234);
    check("mt_lo", 64'(lo), 64'h1234);
    check("mt_busy", 64'(busy), 64'd0);

    // start + mtlo: start wins, wdata dropped.
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    launch(2'b00, 32'd3, 32'd4);
    mtlo = 1'b0;
    check("start_mtlo_drop", 64'(lo), 64'h1234);
    wait_done(MC, "start_mtlo");

    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      launch(op, a, b);
      wait_done(op[1] ? DC : MC, "rand");
    end

    // Async reset in the middle of a DIV.
    launch(2'b10, 32'd1000, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk); reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("no_late_write_hi", 64'(hi), 64'd0);
    check("no_late_write_lo", 64'(lo), 64'd0);
    check("no_late_busy", 64'(busy), 64'd0);
    launch(2'b00, 32'hFFFF_FFF0, 32'h0000_0011);
    wait_done(MC, "post_reset_mult");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
